// File: rtl/m65_keyb_matrix_fifo_pkg.sv
// m65_keyb_pkg: shared register bit positions, FIFO entry layout and key-to-matrix mapping
package m65_keyb_pkg;

   localparam int KB_PEN = 0;
   localparam int KB_EXT = 1;
   localparam int KB_RLS = 2;
   localparam int KB_ERR = 3;
   localparam int KB_BSY = 7;

   localparam int ENT_W       = 8;
   localparam int ENT_RLS     = 7;
   localparam int ENT_KEY_MSB = 6;

   function automatic int key_row(input int k, input int cols);
      return k / cols;
   endfunction

   function automatic int key_col(input int k, input int cols);
      return k % cols;
   endfunction

endpackage

// File: rtl/m65_keyb_matrix_fifo_key_event_fifo.sv
// key_event_fifo: synchronous event queue with extra-bit pointers, flush and overflow flag
module key_event_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full,
   output logic         overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr;
   logic [AW:0]  rd;
   logic         do_pop;
   logic         do_push;

   assign empty    = wr == rd;
   assign full     = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
   assign do_pop   = pop & ~empty & ~flush;
   assign do_push  = push & ~flush & (~full | do_pop);
   assign overflow = push & ~flush & full & ~do_pop;
   assign head     = mem[rd[AW-1:0]];

   // pointer update; flush wins over any push or pop in the same cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr <= '0;
         rd <= '0;
      end else if (flush) begin
         wr <= '0;
         rd <= '0;
      end else begin
         if (do_push) wr <= wr + 1'b1;
         if (do_pop) rd <= rd + 1'b1;
      end

   // storage needs no reset: entries are only read once written
   always_ff @(posedge clk)
      if (do_push) mem[wr[AW-1:0]] <= din;

endmodule

// File: rtl/m65_keyb_matrix_fifo.sv
// m65_keyb_matrix_fifo: key state map, active-low ROWS x COLS matrix and CPU-visible event FIFO
module m65_keyb_matrix_fifo
   import m65_keyb_pkg::*;
#(
   parameter int ROWS       = 8,
   parameter int COLS       = 5,
   parameter int KEYW       = 7,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [KEYW-1:0] key_num,
   input  logic            key_status_n,
   input  logic [ROWS-1:0] row_sel_n,
   output logic [COLS-1:0] col_n,
   input  logic            rd_scancode,
   input  logic            rd_status,
   input  logic            flush,
   output logic [7:0]      scancode_dout,
   output logic [7:0]      kbstatus_dout,
   output logic            irq_n
);

   localparam int NKEYS = 2 ** KEYW;

   logic [1:0]       rst_sync;
   logic             rst_i;
   logic [NKEYS-1:0] state;
   logic             pressed;
   logic             ev;
   logic [6:0]       key7;
   logic [7:0]       head;
   logic             empty;
   logic             overflow;
   logic             err;
   logic [COLS-1:0]  act [ROWS];
   logic [COLS-1:0]  hit;
   logic [7:0]       kb_next;

   // reset asserts immediately, deasserts two clocks after rst_n rises
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rst_sync <= 2'b00;
      else rst_sync <= {rst_sync[0], 1'b1};

   assign rst_i   = rst_sync[1];
   assign pressed = ~key_status_n;
   assign ev      = state[key_num] ^ pressed;
   assign key7    = 7'(key_num);

   // commit the scanned key's state whenever it differs from the map
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) state <= '0;
      else if (ev) state[key_num] <= pressed;

   key_event_fifo #(.W(ENT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_i),
      .push     (ev),
      .pop      (rd_scancode),
      .flush    (flush),
      .din      ({key_status_n, key7}),
      .head     (head),
      .empty    (empty),
      .full     (),
      .overflow (overflow)
   );

   for (genvar k = 0; k < ROWS * COLS; k++) begin : g_key
      if (k < NKEYS) begin : g_on
         assign act[key_row(k, COLS)][key_col(k, COLS)] = state[k] & ~row_sel_n[key_row(k, COLS)];
      end else begin : g_off
         assign act[key_row(k, COLS)][key_col(k, COLS)] = 1'b0;
      end
   end

   // selected rows are wire-ORed onto the column lines
   always_comb begin
      hit = '0;
      for (int r = 0; r < ROWS; r++) hit = hit | act[r];
   end

   // status byte built from the current head and sticky error
   always_comb begin
      kb_next          = '0;
      kb_next[KB_PEN]  = ~empty;
      kb_next[KB_EXT]  = 1'b0;
      kb_next[KB_RLS]  = ~empty & head[ENT_RLS];
      kb_next[KB_ERR]  = err;
      kb_next[KB_BSY]  = 1'b0;
   end

   // sticky overflow error; an overflow beats a same-cycle status read
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) err <= 1'b0;
      else err <= ~flush & (overflow | (err & ~rd_status));

   // registered CPU-facing and matrix outputs
   always_ff @(posedge clk or negedge rst_i)
      if (!rst_i) begin
         col_n         <= '1;
         scancode_dout <= 8'h00;
         kbstatus_dout <= 8'h00;
         irq_n         <= 1'b1;
      end else begin
         col_n         <= ~hit;
         scancode_dout <= empty ? 8'h00 : {1'b0, head[ENT_KEY_MSB:0]};
         kbstatus_dout <= kb_next;
         irq_n         <= empty;
      end

endmodule

// File: tb/tb_m65_keyb_matrix_fifo.sv
// tb_m65_keyb_matrix_fifo: directed and randomized checks against a queue-based keyboard model
module tb_m65_keyb_matrix_fifo;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] key_num = '0;
   logic       key_status_n = 1'b1;
   logic [7:0] row_sel_n = 8'hFF;
   logic [4:0] col_n;
   logic       rd_scancode = 1'b0;
   logic       rd_status = 1'b0;
   logic       flush = 1'b0;
   logic [7:0] scancode_dout;
   logic [7:0] kbstatus_dout;
   logic       irq_n;

   int checks = 0;
   int fails = 0;

   bit         mmap [128];
   logic [7:0] q [$];
   bit         merr;
   logic [7:0] row_sel = 8'hFF;
   logic [4:0] exp_col;
   logic [7:0] exp_sc;
   logic [7:0] exp_st;
   logic       exp_irq;

   always #5 clk = ~clk;

   m65_keyb_matrix_fifo dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .key_num       (key_num),
      .key_status_n  (key_status_n),
      .row_sel_n     (row_sel_n),
      .col_n         (col_n),
      .rd_scancode   (rd_scancode),
      .rd_status     (rd_status),
      .flush         (flush),
      .scancode_dout (scancode_dout),
      .kbstatus_dout (kbstatus_dout),
      .irq_n         (irq_n)
   );

   task automatic model_clear();
      foreach (mmap[i]) mmap[i] = 1'b0;
      q.delete();
      merr = 1'b0;
   endtask

   // one clock: drive inputs, capture what the outputs must show after this edge, advance the model
   task automatic tick(input logic [6:0] k, input bit sn, input bit rsc, input bit rst_, input bit fl);
      bit ev;
      bit ov;
      key_num = k;
      key_status_n = sn;
      rd_scancode = rsc;
      rd_status = rst_;
      flush = fl;
      row_sel_n = row_sel;
      exp_col = 5'b11111;
      for (int i = 0; i < 40; i++) if (mmap[i] && !row_sel[i / 5]) exp_col[i % 5] = 1'b0;
      exp_sc = (q.size() != 0) ? {1'b0, q[0][6:0]} : 8'h00;
      exp_st = {4'b0000, merr, (q.size() != 0) ? q[0][7] : 1'b0, 1'b0, q.size() != 0};
      exp_irq = q.size() == 0;
      @(posedge clk);
      ev = mmap[k] != !sn;
      if (ev) mmap[k] = !sn;
      if (fl) begin
         q.delete();
         merr = 1'b0;
      end else begin
         if (rsc && q.size() != 0) void'(q.pop_front());
         ov = 1'b0;
         if (ev) begin
            if (q.size() < 8) q.push_back({sn, k});
            else ov = 1'b1;
         end
         merr = ov | (merr & !rst_);
      end
      #1;
      rd_scancode = 1'b0;
      rd_status = 1'b0;
      flush = 1'b0;
   endtask

   // scan a random key whose reported status matches the map, so no event is produced
   task automatic tick_idle(input bit rsc, input bit rst_, input bit fl);
      logic [6:0] k;
      k = 7'($urandom_range(0, 127));
      tick(k, !mmap[k], rsc, rst_, fl);
   endtask

   task automatic test_reset();
      row_sel = 8'h00;
      rst_n = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) tick(7'($urandom_range(0, 39)), $urandom_range(0, 1) == 0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      model_clear();
      #1;
      checks++; if (col_n !== 5'b11111) begin fails++; $display("FAIL reset col_n got %b exp 11111", col_n); end
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL reset kbstatus got %h exp 00", kbstatus_dout); end
      checks++; if (scancode_dout !== 8'h00) begin fails++; $display("FAIL reset scancode got %h exp 00", scancode_dout); end
      checks++; if (irq_n !== 1'b1) begin fails++; $display("FAIL reset irq_n got %b exp 1", irq_n); end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick_idle(1'b0, 1'b0, 1'b0);
         checks++;
         if (col_n !== 5'b11111 || kbstatus_dout !== 8'h00 || scancode_dout !== 8'h00 || irq_n !== 1'b1) begin
            fails++;
            $display("FAIL post_reset cycle %0d got col %b st %h sc %h irq %b exp 11111 00 00 1", i, col_n, kbstatus_dout, scancode_dout, irq_n);
         end
      end
   endtask

   task automatic test_single_key();
      row_sel = 8'hFB;
      tick(7'd12, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (col_n !== 5'b11011) begin fails++; $display("FAIL single col_n got %b exp 11011", col_n); end
      checks++; if (kbstatus_dout !== 8'h01) begin fails++; $display("FAIL single kbstatus got %h exp 01", kbstatus_dout); end
      checks++; if (scancode_dout !== 8'h0C) begin fails++; $display("FAIL single scancode got %h exp 0c", scancode_dout); end
      checks++; if (irq_n !== 1'b0) begin fails++; $display("FAIL single irq_n got %b exp 0", irq_n); end
      tick_idle(1'b1, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL single_pop kbstatus got %h exp 00", kbstatus_dout); end
      checks++; if (irq_n !== 1'b1) begin fails++; $display("FAIL single_pop irq_n got %b exp 1", irq_n); end
      tick(7'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h05) begin fails++; $display("FAIL single_rls kbstatus got %h exp 05", kbstatus_dout); end
      checks++; if (scancode_dout !== 8'h0C) begin fails++; $display("FAIL single_rls scancode got %h exp 0c", scancode_dout); end
      checks++; if (col_n !== 5'b11111) begin fails++; $display("FAIL single_rls col_n got %b exp 11111", col_n); end
      tick_idle(1'b1, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_multi_row();
      tick(7'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(7'd6, 1'b0, 1'b0, 1'b0, 1'b0);
      row_sel = 8'hFC;
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (col_n !== 5'b11100) begin fails++; $display("FAIL multi_row col_n got %b exp 11100", col_n); end
      row_sel = 8'hFF;
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (col_n !== 5'b11111) begin fails++; $display("FAIL multi_none col_n got %b exp 11111", col_n); end
      tick(7'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(7'd6, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b1);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL multi_flush kbstatus got %h exp 00", kbstatus_dout); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 9; i++) tick(7'(20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h09) begin fails++; $display("FAIL overflow kbstatus got %h exp 09", kbstatus_dout); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (scancode_dout !== 8'(20 + i)) begin fails++; $display("FAIL overflow_order entry %0d got %h exp %h", i, scancode_dout, 8'(20 + i)); end
         tick_idle(1'b1, 1'b0, 1'b0);
         tick_idle(1'b0, 1'b0, 1'b0);
      end
      checks++; if (kbstatus_dout !== 8'h08) begin fails++; $display("FAIL overflow_drained kbstatus got %h exp 08", kbstatus_dout); end
      tick_idle(1'b0, 1'b1, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL overflow_clear kbstatus got %h exp 00", kbstatus_dout); end
      for (int i = 0; i < 9; i++) tick(7'(20 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < 8; i++) tick(7'(30 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h01) begin fails++; $display("FAIL full kbstatus got %h exp 01", kbstatus_dout); end
      tick(7'd38, 1'b0, 1'b1, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h01) begin fails++; $display("FAIL full_pushpop kbstatus got %h exp 01", kbstatus_dout); end
      checks++; if (scancode_dout !== 8'h1F) begin fails++; $display("FAIL full_pushpop scancode got %h exp 1f", scancode_dout); end
      tick(7'd39, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h09) begin fails++; $display("FAIL ovf_vs_status kbstatus got %h exp 09", kbstatus_dout); end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (scancode_dout !== 8'(31 + i)) begin fails++; $display("FAIL full_order entry %0d got %h exp %h", i, scancode_dout, 8'(31 + i)); end
         tick_idle(1'b1, 1'b0, 1'b0);
         tick_idle(1'b0, 1'b0, 1'b0);
      end
      checks++; if (kbstatus_dout !== 8'h08) begin fails++; $display("FAIL full_drained kbstatus got %h exp 08", kbstatus_dout); end
      for (int i = 0; i < 10; i++) tick(7'(30 + i), 1'b1, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b1);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL full_flush kbstatus got %h exp 00", kbstatus_dout); end
   endtask

   task automatic test_out_of_matrix();
      tick(7'd100, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (scancode_dout !== 8'h64) begin fails++; $display("FAIL oom scancode got %h exp 64", scancode_dout); end
      checks++; if (kbstatus_dout !== 8'h01) begin fails++; $display("FAIL oom kbstatus got %h exp 01", kbstatus_dout); end
      for (int r = 0; r <= 8; r++) begin
         row_sel = (r == 8) ? 8'h00 : ~(8'h01 << r);
         tick_idle(1'b0, 1'b0, 1'b0);
         tick_idle(1'b0, 1'b0, 1'b0);
         checks++; if (col_n !== 5'b11111) begin fails++; $display("FAIL oom_col row_sel %h got %b exp 11111", row_sel, col_n); end
      end
      tick(7'd100, 1'b0, 1'b0, 1'b0, 1'b1);
      tick_idle(1'b0, 1'b0, 1'b0);
      checks++; if (kbstatus_dout !== 8'h00) begin fails++; $display("FAIL oom_flush kbstatus got %h exp 00", kbstatus_dout); end
      tick(7'd100, 1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_random();
      logic [6:0] k;
      for (int n = 0; n < 600; n++) begin
         row_sel = 8'($urandom);
         k = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(40, 127)) : 7'($urandom_range(0, 39));
         tick(k, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 40) == 0);
         checks++;
         if (col_n !== exp_col || scancode_dout !== exp_sc || kbstatus_dout !== exp_st || irq_n !== exp_irq) begin
            fails++;
            $display("FAIL random cycle %0d got col %b sc %h st %h irq %b exp %b %h %h %b", n, col_n, scancode_dout, kbstatus_dout, irq_n, exp_col, exp_sc, exp_st, exp_irq);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_key();
      test_multi_row();
      test_overflow();
      test_full_boundary();
      test_out_of_matrix();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/m65_keyb_matrix_fifo.md
Name: m65_keyb_matrix_fifo

Overview:
Parametrised successor to the fixed MEGA65-to-Spectrum keyboard bridge. It tracks the pressed/released state of every key from the M2M key scan stream and drives a generic ROWS x COLS active-low matrix. It also queues press/release events in a FIFO, read by the CPU through the SCANCODE and KBSTATUS registers with a real pending/overflow status. It sits between the M2M keyboard interface and the core's register file and ULA row/column logic.

Parameters:
ROWS, 8, number of matrix rows (row select width)
COLS, 5, number of matrix columns (column data width)
KEYW, 7, width of key_num; at most 7
FIFO_DEPTH, 8, event FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_num  in  KEYW  M2M scanned key index, changes every clk
key_status_n  in  1  0 = key_num currently pressed
row_sel_n  in  ROWS  active-low row select from ULA port address
col_n  out  COLS  active-low column data, registered
rd_scancode  in  1  single-cycle pulse issued after the CPU finishes reading SCANCODE; pops the FIFO
rd_status  in  1  single-cycle pulse issued after the CPU finishes reading KBSTATUS; clears sticky ERR
flush  in  1  single-cycle pulse; empties the FIFO and clears ERR; does not touch the key state map
scancode_dout  out  8  {1'b0, head key index zero-extended to 7 bits}; 8'h00 when the FIFO is empty
kbstatus_dout  out  8  {BSY=0, 3'b000, ERR, RLS, EXT=0, PEN}
irq_n  out  1  low while PEN=1

Behaviour:
- Reset (async, rst_n=0):
  - key state map cleared; FIFO empty; col_n all ones; kbstatus_dout = 8'h00; scancode_dout = 8'h00; irq_n = 1.
  - Release of reset is synchronised internally with a 2-flop deassert.
- Key mapping:
  - Key k with k < ROWS*COLS maps to row k/COLS, column k%COLS.
  - Keys with k >= ROWS*COLS are tracked and queued but are never shown on the matrix.
- Key state map:
  - One bit per key, 2**KEYW bits.
  - Each clk, compare pressed = ~key_status_n against the stored bit for key_num.
  - On a difference: update the bit and generate an event {rls = key_status_n, key = key_num}.
  - No difference means no event. An event is generated and committed in the same cycle.
- Matrix:
  - col_n[c] = NOT(OR over r of (state[r*COLS+c] AND NOT row_sel_n[r])), registered.
  - Latency is 1 clk from a row_sel_n or state change to col_n.
  - Multiple rows selected at once are ORed, as on real Spectrum hardware.
- FIFO:
  - Synchronous, FIFO_DEPTH entries of 8 bits {rls, key[6:0]}, pointers of clog2(FIFO_DEPTH)+1 bits.
  - Push happens on an event; pop happens on rd_scancode.
  - Push on full drops the new event and sets ERR. The map still updates, so the matrix stays correct.
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Pop on empty is ignored.
  - Push and pop in the same cycle while empty: the event is pushed and the pop is ignored.
- Outputs:
  - scancode_dout and kbstatus_dout are registered and reflect the head 1 clk after any push, pop or flush.
  - PEN = FIFO not empty. RLS = rls bit of the head entry, 0 when empty.
- ERR:
  - Sticky; cleared by rd_status or flush.
  - If rd_status and an overflow occur in the same cycle, ERR stays set.
- flush with a simultaneous event: the FIFO is emptied and the event is dropped, but the map is updated.

Decomposition:
- Package m65_keyb_pkg:
  - KBSTATUS bit positions: PEN=0, EXT=1, RLS=2, ERR=3, BSY=7.
  - FIFO entry field positions.
  - Function mapping a key index to row and column.
- One sub-module key_event_fifo (parametrised width and depth):
  - push, pop, flush inputs; head, empty, full, overflow outputs.

Test Plan:
- Reset: hold rst_n=0 mid-scan -> col_n=5'b11111, kbstatus_dout=8'h00, scancode_dout=8'h00, irq_n=1; all unchanged for 4 clk after release with no key pressed.
- Single key: key 12 pressed (row 2, col 2), row_sel_n=8'hFB -> col_n=5'b11011 one clk later; kbstatus=8'h01, scancode=8'h0C. Pulse rd_scancode -> kbstatus=8'h00. Release key 12 -> kbstatus=8'h05.
- Multi-row: keys 0 and 6 pressed, row_sel_n=8'hFC -> col_n=5'b11100; row_sel_n=8'hFF -> col_n=5'b11111.
- Overflow: 9 distinct presses, no pops, FIFO_DEPTH=8 -> kbstatus=8'h09, and 8 pops return the first 8 keys in order. rd_status -> ERR cleared.
- Full boundary: FIFO full, event and rd_scancode in the same cycle -> no ERR, still 8 entries, new event last.
- Out-of-matrix key 100 pressed -> queued (scancode=8'h64), col_n unchanged for all row selects. flush -> kbstatus=8'h00.
